me_msad_tracker: RTL and testbench

Sequential minimum-SAD tracker for the motion-estimation datapath. Consumes one batch of `PIXELS_IN_BATCH` candidate SADs per valid cycle from the ADD_8 stage. Finds the batch minimum, tracks the running minimum over a full `SEARCH_W` x `SEARCH_H` candidate window, and reports the best SAD with its signed motion vector once per current block. It generalises the combinational 16-way minimum into a parametrised, pipelined, window-level search with a block handshake.

---
 rtl/me_pkg.sv | 32 +++
 rtl/me_min_tree.sv | 40 ++++
 rtl/me_msad_tracker.sv | 177 +++++++++++++++++
 tb/tb_me_msad_tracker.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// me_pkg: shared constants and types for the motion-estimation min-SAD tracker.
//   - default geometry / width constants (overridable per instance)
//   - me_state_e : window FSM state (IDLE, RUN)
//   - me_s1_t    : stage-1 payload (batch minimum, its column/row, window tags)
package me_pkg;

  localparam int PIXELS_IN_BATCH = 16;
  localparam int SAD_BIT_WIDTH   = 14;
  localparam int SEARCH_W        = 32;
  localparam int SEARCH_H        = 32;
  localparam int MV_BIT_WIDTH    = 6;
  localparam int ZMV_BIAS        = 16;

  localparam int COL_W = $clog2(SEARCH_W);
  localparam int ROW_W = $clog2(SEARCH_H);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } me_state_e;

  // Widths follow the package defaults above.
  typedef struct packed {
    logic [SAD_BIT_WIDTH-1:0] value;
    logic [COL_W-1:0]         col;
    logic [ROW_W-1:0]         row;
    logic                     first;
    logic                     last;
    logic                     valid;
  } me_s1_t;

endpackage

// File: rtl/me_min_tree.sv
// me_min_tree: combinational N-way minimum with index.
//   vals    : N packed values, element k is candidate k
//   min_val : smallest value
//   min_idx : index of the smallest value; ties resolve to the lower index
// Built as a heap-ordered binary tree: leaves at N..2N-1, node i merges 2i
// (lower indices) and 2i+1, so keeping the left child on ties gives the
// lowest-index winner. N must be a power of two.
module me_min_tree #(
  parameter int N  = 16,
  parameter int W  = 14,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0][W-1:0] vals,
  output logic [W-1:0]        min_val,
  output logic [IW-1:0]       min_idx
);

  logic [W-1:0]  nv [1:2*N-1];
  logic [IW-1:0] ni [1:2*N-1];

  always_comb begin
    for (int k = 0; k < N; k++) begin
      nv[N+k] = vals[k];
      ni[N+k] = IW'(k);
    end
    for (int i = N - 1; i >= 1; i--) begin
      if (nv[2*i+1] < nv[2*i]) begin
        nv[i] = nv[2*i+1];
        ni[i] = ni[2*i+1];
      end else begin
        nv[i] = nv[2*i];
        ni[i] = ni[2*i];
      end
    end
  end

  assign min_val = nv[1];
  assign min_idx = ni[1];

endmodule

// File: rtl/me_msad_tracker.sv
// me_msad_tracker: window-level minimum-SAD search with block handshake.
// Ports:
//   clk, rst            : clock (rising edge), asynchronous active-low reset
//   start_i             : pulse, opens a new SEARCH_W x SEARCH_H window
//   batch_valid_i       : sad_batch_i holds PIXELS_IN_BATCH SADs of one row
//   sad_batch_i         : candidate k at [(k+1)*SAD_BIT_WIDTH-1 : k*SAD_BIT_WIDTH]
//   busy_o              : window open
//   done_o              : pulse, best_* outputs just updated
//   best_sad_o          : window minimum
//   best_mv_x_o/_y_o    : signed vector of the winner (col - W/2, row - H/2)
//   err_o               : pulse, protocol violation seen the cycle before
// Pipeline: stage 1 = batch min tree + tags, stage 2 = running minimum/result.
// Build option: define ME_ZMV_BIAS_EN to subtract ZMV_BIAS (saturating) from
// the zero-vector candidate before the tree.
module me_msad_tracker #(
  parameter int PIXELS_IN_BATCH = me_pkg::PIXELS_IN_BATCH,
  parameter int SAD_BIT_WIDTH   = me_pkg::SAD_BIT_WIDTH,
  parameter int SEARCH_W        = me_pkg::SEARCH_W,
  parameter int SEARCH_H        = me_pkg::SEARCH_H,
  parameter int MV_BIT_WIDTH    = me_pkg::MV_BIT_WIDTH
`ifdef ME_ZMV_BIAS_EN
  ,parameter int ZMV_BIAS       = me_pkg::ZMV_BIAS
`endif
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start_i,
  input  logic                                     batch_valid_i,
  input  logic [PIXELS_IN_BATCH*SAD_BIT_WIDTH-1:0] sad_batch_i,
  output logic                                     busy_o,
  output logic                                     done_o,
  output logic [SAD_BIT_WIDTH-1:0]                 best_sad_o,
  output logic [MV_BIT_WIDTH-1:0]                  best_mv_x_o,
  output logic [MV_BIT_WIDTH-1:0]                  best_mv_y_o,
  output logic                                     err_o
);
  import me_pkg::*;

  localparam int BCOLS  = SEARCH_W / PIXELS_IN_BATCH;
  localparam int BCOL_W = (BCOLS > 1) ? $clog2(BCOLS) : 1;
  localparam int K_W    = (PIXELS_IN_BATCH > 1) ? $clog2(PIXELS_IN_BATCH) : 1;

  me_state_e          state, state_nxt;
  logic [BCOL_W-1:0]  bcol;
  logic [ROW_W-1:0]   row;
  logic               accept, first_batch, last_batch, err_nxt;

  assign accept      = (state == RUN) && batch_valid_i;
  assign first_batch = (bcol == '0) && (row == '0);
  assign last_batch  = (bcol == BCOL_W'(BCOLS - 1)) && (row == ROW_W'(SEARCH_H - 1));
  assign busy_o      = (state == RUN);

  // ---------------- window FSM ----------------
  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i)       state_nxt = RUN;
        if (batch_valid_i) err_nxt   = 1'b1;  // batch outside a window is dropped
      end
      RUN: begin
        if (accept && last_batch) state_nxt = IDLE;
        if (start_i)              err_nxt   = 1'b1;  // window carries on
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      bcol  <= '0;
      row   <= '0;
      err_o <= 1'b0;
    end else begin
      state <= state_nxt;
      err_o <= err_nxt;
      if (state == IDLE && start_i) begin
        bcol <= '0;
        row  <= '0;
      end else if (accept) begin
        if (bcol == BCOL_W'(BCOLS - 1)) begin
          bcol <= '0;
          row  <= (row == ROW_W'(SEARCH_H - 1)) ? '0 : row + 1'b1;
        end else begin
          bcol <= bcol + 1'b1;
        end
      end
    end
  end

  // ---------------- per-lane input conditioning ----------------
  logic [PIXELS_IN_BATCH-1:0][SAD_BIT_WIDTH-1:0] lane_sad;

`ifdef ME_ZMV_BIAS_EN
  for (genvar k = 0; k < PIXELS_IN_BATCH; k++) begin : g_lane
    logic [SAD_BIT_WIDTH-1:0] raw;
    logic                     zmv;
    assign raw = sad_batch_i[k*SAD_BIT_WIDTH +: SAD_BIT_WIDTH];
    // Lane sits on the zero vector when its column/row are the window centre.
    assign zmv = (int'(bcol) * PIXELS_IN_BATCH + k == SEARCH_W / 2) &&
                 (int'(row) == SEARCH_H / 2);
    assign lane_sad[k] = !zmv ? raw :
                         (raw > SAD_BIT_WIDTH'(ZMV_BIAS)) ? raw - SAD_BIT_WIDTH'(ZMV_BIAS) : '0;
  end
`else
  assign lane_sad = sad_batch_i;
`endif

  // ---------------- stage 1: batch minimum ----------------
  logic [SAD_BIT_WIDTH-1:0] min_val;
  logic [K_W-1:0]           min_idx;
  me_s1_t                   s1;

  me_min_tree #(
    .N (PIXELS_IN_BATCH),
    .W (SAD_BIT_WIDTH)
  ) u_tree (
    .vals    (lane_sad),
    .min_val (min_val),
    .min_idx (min_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
    end else begin
      s1.valid <= accept;
      if (accept) begin
        s1.value <= min_val;
        s1.col   <= COL_W'(int'(bcol) * PIXELS_IN_BATCH + int'(min_idx));
        s1.row   <= row;
        s1.first <= first_batch;
        s1.last  <= last_batch;
      end
    end
  end

  // ---------------- stage 2: running minimum ----------------
  // Strict less-than keeps the raster-earlier candidate on ties; the first
  // batch of a window reloads unconditionally so windows never mix.
  logic [SAD_BIT_WIDTH-1:0] run_sad, fin_sad;
  logic [COL_W-1:0]         run_col, fin_col;
  logic [ROW_W-1:0]         run_row, fin_row;
  logic                     take;

  assign take    = s1.first || (s1.value < run_sad);
  assign fin_sad = take ? s1.value : run_sad;
  assign fin_col = take ? s1.col   : run_col;
  assign fin_row = take ? s1.row   : run_row;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_sad     <= '0;
      run_col     <= '0;
      run_row     <= '0;
      done_o      <= 1'b0;
      best_sad_o  <= '0;
      best_mv_x_o <= '0;
      best_mv_y_o <= '0;
    end else begin
      done_o <= s1.valid && s1.last;
      if (s1.valid) begin
        run_sad <= fin_sad;
        run_col <= fin_col;
        run_row <= fin_row;
      end
      if (s1.valid && s1.last) begin
        best_sad_o  <= fin_sad;
        best_mv_x_o <= MV_BIT_WIDTH'(int'(fin_col) - SEARCH_W / 2);
        best_mv_y_o <= MV_BIT_WIDTH'(int'(fin_row) - SEARCH_H / 2);
      end
    end
  end

endmodule

// File: tb/tb_me_msad_tracker.sv
// Directed bench for me_msad_tracker at default parameters. Expected results
// are hand-derived per test; the zero-vector bias build changes a few of them.
module tb_me_msad_tracker;

  localparam int PIB = 16;
  localparam int SW  = 14;
  localparam int SWW = 32;
  localparam int SWH = 32;
  localparam int MVW = 6;
  localparam int NB  = 64;
  localparam int BC  = SWW / PIB;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start_i = 1'b0;
  logic                batch_valid_i = 1'b0;
  logic [PIB*SW-1:0]   sad_batch_i = '0;
  logic                busy_o, done_o, err_o;
  logic [SW-1:0]       best_sad_o;
  logic signed [MVW-1:0] best_mv_x_o, best_mv_y_o;

  me_msad_tracker dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .batch_valid_i (batch_valid_i),
    .sad_batch_i   (sad_batch_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .best_sad_o    (best_sad_o),
    .best_mv_x_o   (best_mv_x_o),
    .best_mv_y_o   (best_mv_y_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int d_sad [16];
  int d_mvx [16];
  int d_mvy [16];
  int d_cyc [16];
  int lastc = 0;
  int sad_map [2][SWH][SWW];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done_o) begin
      if (done_cnt < 16) begin
        d_sad[done_cnt] = int'(best_sad_o);
        d_mvx[done_cnt] = int'(best_mv_x_o);
        d_mvy[done_cnt] = int'(best_mv_y_o);
        d_cyc[done_cnt] = cyc;
      end
      done_cnt++;
    end
    if (err_o) err_cnt++;
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input int w, input int v);
    for (int r = 0; r < SWH; r++)
      for (int c = 0; c < SWW; c++) sad_map[w][r][c] = v;
  endtask

  task automatic slot(input bit s, input bit v, input int w, input int r, input int bc);
    @(posedge clk); #1;
    start_i       = s;
    batch_valid_i = v;
    for (int k = 0; k < PIB; k++) sad_batch_i[k*SW +: SW] = SW'(sad_map[w][r][bc*PIB+k]);
  endtask

  task automatic idle();
    slot(1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_err"},  err_o, 0);
    chk({tag, "_sad"},  best_sad_o, 0);
    chk({tag, "_mvx"},  best_mv_x_o, 0);
    chk({tag, "_mvy"},  best_mv_y_o, 0);
  endtask

  // One window: start slot (optionally with a stray batch), 64 batches,
  // optional start pulse on batch 'inj', optional reset before batch 'abort'.
  task automatic run_window(input int w, input bit sv, input int inj, input int abort);
    slot(1'b1, sv, w, 0, 0);
    @(negedge clk); chk("busy_at_start", busy_o, 0);
    for (int b = 0; b < NB; b++) begin
      if (abort == b) begin
        @(posedge clk); #1;
        rst = 1'b0; start_i = 1'b0; batch_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("in_reset");
        rst = 1'b1;
        return;
      end
      slot(inj == b, 1'b1, w, b / BC, b % BC);
      if (b == 0) begin
        @(negedge clk); chk("busy_run", busy_o, 1);
      end
    end
    lastc = cyc;
  endtask

  task automatic wait_done(input int n, input string tag);
    int t = 0;
    while (done_cnt < n && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done_count"}, done_cnt, n);
  endtask

  task automatic check_res(input int i, input string tag, input int s, input int x, input int y);
    chk({tag, "_sad"}, d_sad[i], s);
    chk({tag, "_mvx"}, d_mvx[i], x);
    chk({tag, "_mvy"}, d_mvy[i], y);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n, e0, lasta;

    // reset state
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;

    // T1: single winner 37 at col 20, row 5
    fill(0, 1000); sad_map[0][5][20] = 37;
    run_window(0, 1'b0, -1, -1); idle();
    wait_done(1, "t1");
    chk("t1_latency", d_cyc[0] - lastc, 2);
    chk("t1_busy_after", busy_o, 0);
    check_res(0, "t1", 37, 4, -11);
    chk("t1_no_err", err_cnt, 0);

    // T2: flat 500, first candidate wins ties
    fill(0, 500);
    run_window(0, 1'b0, -1, -1); idle();
    wait_done(2, "t2");
`ifdef ME_ZMV_BIAS_EN
    check_res(1, "t2", 484, 0, 0);
`else
    check_res(1, "t2", 500, -16, -16);
`endif

    // T3: back-to-back windows
    fill(0, 1000); sad_map[0][16][16] = 12;
    fill(1, 1000); sad_map[1][31][31] = 99;
    run_window(0, 1'b0, -1, -1); lasta = lastc;
    run_window(1, 1'b0, -1, -1); idle();
    wait_done(4, "t3");
    chk("t3a_latency", d_cyc[2] - lasta, 2);
    chk("t3b_latency", d_cyc[3] - lastc, 2);
`ifdef ME_ZMV_BIAS_EN
    check_res(2, "t3a", 0, 0, 0);
`else
    check_res(2, "t3a", 12, 0, 0);
`endif
    check_res(3, "t3b", 99, 15, 15);

    // T4: protocol violations around the T1 window
    fill(0, 1000); sad_map[0][5][20] = 37;
    e0 = err_cnt;
    slot(1'b0, 1'b1, 0, 0, 0);            // batch while idle
    run_window(0, 1'b1, 10, -1); idle();  // start+batch in idle, start mid-window
    wait_done(5, "t4");
    chk("t4_err_pulses", err_cnt - e0, 3);
    check_res(4, "t4", 37, 4, -11);

    // T5: reset after 30 batches, then a fresh window
    n = done_cnt;
    run_window(0, 1'b0, -1, 30);
    repeat (10) idle();
    chk("t5_no_done_aborted", done_cnt, n);
    fill(0, 1000); sad_map[0][30][7] = 5;
    run_window(0, 1'b0, -1, -1); idle();
    wait_done(n + 1, "t5");
    check_res(n, "t5", 5, -9, 14);

    // T6: zero-vector bias
    fill(0, 1000); sad_map[0][16][16] = 50; sad_map[0][18][19] = 40;
    run_window(0, 1'b0, -1, -1); idle();
    wait_done(n + 2, "t6");
`ifdef ME_ZMV_BIAS_EN
    check_res(n + 1, "t6", 34, 0, 0);
`else
    check_res(n + 1, "t6", 40, 3, 2);
`endif

    repeat (3) idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
